// File: rtl/pipe_scoreboard_pkg.sv
// Shared types for the WISC hazard/forward scoreboard.
// Entry layout, regfile select code and decoder opcodes.
package pipe_scb_pkg;

  localparam int MAX_RA_W = 8;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [MAX_RA_W-1:0] rd;
    logic                wr;
    logic                load;
    logic                fset;
    logic                hlt;
  } scb_entry_t;

  localparam scb_entry_t SCB_BUBBLE = '0;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  function automatic logic op_sets_flags(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_XOR,
                      OP_SLL, OP_SRA, OP_ROR};
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage <-> scoreboard bundle.
// master = decoder/ID side, slave = scoreboard.
interface pipe_scoreboard_if #(
  parameter int RA_W  = 4,
  parameter int SEL_W = 2
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_is_load;
  logic            id_flag_set;
  logic            id_flag_read;
  logic            id_hlt;
  logic            flush;
  logic             stall;
  logic             issue;
  logic [SEL_W-1:0] fwd_sel_rs;
  logic [SEL_W-1:0] fwd_sel_rt;
  logic             drained;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_rs_used, id_rt_used,
    output id_rd, id_reg_write, id_is_load,
    output id_flag_set, id_flag_read,
    output id_hlt, flush,
    input  stall, issue,
    input  fwd_sel_rs, fwd_sel_rt, drained
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_rs_used, id_rt_used,
    input  id_rd, id_reg_write, id_is_load,
    input  id_flag_set, id_flag_read,
    input  id_hlt, flush,
    output stall, issue,
    output fwd_sel_rs, fwd_sel_rt, drained
  );
endinterface

// File: rtl/pipe_scoreboard_src_match.sv
// Youngest-writer finder for one ID source register.
// Ports: scoreboard columns in, {hit, ready, sel} out.
module scb_src_match
  import pipe_scb_pkg::*;
#(
  parameter int RA_W    = 4,
  parameter int DEPTH   = 3,
  parameter int ALU_RDY = 1,
  parameter int LD_RDY  = 2,
  parameter bit FWD_EN  = 1'b1,
  localparam int SEL_W  = $clog2(DEPTH+1)
) (
  input  logic [DEPTH:1]               vld,
  input  logic [DEPTH:1]               wr,
  input  logic [DEPTH:1]               ld,
  input  logic [DEPTH:1][MAX_RA_W-1:0] rd,
  input  logic [RA_W-1:0]              src,
  input  logic                         used,
  output logic                         hit,
  output logic                         ready,
  output logic [SEL_W-1:0]             sel
);

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = SEL_W'(SEL_REGFILE);
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && src != '0 && vld[k] && wr[k] &&
          rd[k] == MAX_RA_W'(src)) begin
        hit   = 1'b1;
        ready = k >= (ld[k] ? LD_RDY : ALU_RDY);
        sel   = FWD_EN ? SEL_W'(k)
                       : SEL_W'(SEL_REGFILE);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// In-order hazard/forward scoreboard behind ID.
// Ports: clk, rst (sync, high), sb (slave). Macro: SCB_FWD_EN.
module pipe_scoreboard
  import pipe_scb_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  localparam int RA_W  = $clog2(NUM_REGS),
  localparam int SEL_W = $clog2(DEPTH+1)
) (
  input logic clk,
  input logic rst,
  pipe_scoreboard_if.slave sb
);

`ifdef SCB_FWD_EN
  localparam bit FWD_EN  = 1'b1;
  localparam int ALU_RDY = 1;
  localparam int LD_RDY  = LOAD_STAGE;
`else
  // Without bypass paths only the regfile's
  // internal write-through helps.
  localparam bit FWD_EN  = 1'b0;
  localparam int ALU_RDY = DEPTH;
  localparam int LD_RDY  = (LOAD_STAGE > DEPTH)
                         ? LOAD_STAGE : DEPTH;
`endif

  scb_entry_t ent_q [1:DEPTH];
  scb_entry_t id_ent;
  logic       halted_q;
  logic       drained_q;

  logic [DEPTH:1]               vld_v;
  logic [DEPTH:1]               wr_v;
  logic [DEPTH:1]               ld_v;
  logic [DEPTH:1][MAX_RA_W-1:0] rd_v;
  logic any_valid;
  logic any_hlt;
  logic fset_busy;

  logic             rs_hit, rs_rdy;
  logic             rt_hit, rt_rdy;
  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             stall_c, issue_c;
  logic             drain_now;

  // R0 writes are dropped so R0 is never a writer.
  always_comb begin
    id_ent       = SCB_BUBBLE;
    id_ent.valid = 1'b1;
    id_ent.rd    = MAX_RA_W'(sb.id_rd);
    id_ent.wr    = sb.id_reg_write
                 & (sb.id_rd != '0);
    id_ent.load  = sb.id_is_load;
    id_ent.fset  = sb.id_flag_set;
    id_ent.hlt   = sb.id_hlt;
  end

  always_comb begin
    vld_v     = '0;
    wr_v      = '0;
    ld_v      = '0;
    rd_v      = '0;
    any_valid = 1'b0;
    any_hlt   = 1'b0;
    fset_busy = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      vld_v[k]  = ent_q[k].valid;
      wr_v[k]   = ent_q[k].wr;
      ld_v[k]   = ent_q[k].load;
      rd_v[k]   = ent_q[k].rd;
      any_valid = any_valid | ent_q[k].valid;
      any_hlt   = any_hlt
                | (ent_q[k].valid & ent_q[k].hlt);
      // Flags are committed by the last stage.
      if (k < DEPTH)
        fset_busy = fset_busy
                  | (ent_q[k].valid & ent_q[k].fset);
    end
  end

  scb_src_match #(
    .RA_W    (RA_W),
    .DEPTH   (DEPTH),
    .ALU_RDY (ALU_RDY),
    .LD_RDY  (LD_RDY),
    .FWD_EN  (FWD_EN)
  ) u_rs (
    .vld   (vld_v),
    .wr    (wr_v),
    .ld    (ld_v),
    .rd    (rd_v),
    .src   (sb.id_rs),
    .used  (sb.id_rs_used),
    .hit   (rs_hit),
    .ready (rs_rdy),
    .sel   (rs_sel)
  );

  scb_src_match #(
    .RA_W    (RA_W),
    .DEPTH   (DEPTH),
    .ALU_RDY (ALU_RDY),
    .LD_RDY  (LD_RDY),
    .FWD_EN  (FWD_EN)
  ) u_rt (
    .vld   (vld_v),
    .wr    (wr_v),
    .ld    (ld_v),
    .rd    (rd_v),
    .src   (sb.id_rt),
    .used  (sb.id_rt_used),
    .hit   (rt_hit),
    .ready (rt_rdy),
    .sel   (rt_sel)
  );

  always_comb begin
    stall_c = sb.id_valid & ~halted_q &
              ((rs_hit & ~rs_rdy) |
               (rt_hit & ~rt_rdy) |
               (sb.id_flag_read & fset_busy));
    issue_c = sb.id_valid & ~stall_c
            & ~sb.flush & ~halted_q;
    drain_now = halted_q & ~any_valid & ~any_hlt;
  end

  assign sb.stall      = stall_c;
  assign sb.issue      = issue_c;
  assign sb.fwd_sel_rs = rs_sel;
  assign sb.fwd_sel_rt = rt_sel;
  assign sb.drained    = drained_q | drain_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++)
        ent_q[k] <= SCB_BUBBLE;
      halted_q  <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      ent_q[1] <= issue_c ? id_ent : SCB_BUBBLE;
      for (int k = 2; k <= DEPTH; k++)
        ent_q[k] <= ent_q[k-1];
      if (issue_c && sb.id_hlt)
        halted_q <= 1'b1;
      if (drain_now)
        drained_q <= 1'b1;
    end
  end

endmodule
